// File: rtl/sincos_arbiter.sv
// ---------------------------------------------------------------------------
// sincos_arbiter
//
// Shares one pipelined fixed-point sin/cos unit between NUM_REQ requesters.
// A round-robin arbiter picks at most one requester per cycle and forwards
// its angle/scale operands straight to the unit. The block keeps a tag pipe
// that runs in lockstep with the unit. The tag pipe records which requester
// each in-flight operation belongs to, so the result can be steered back
// exactly LATENCY enabled cycles later. The unit is clock-enabled only while
// there is work in flight, and it freezes when idle.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req_valid    [NUM_REQ]      per-requester request valid
//   req_ready    [NUM_REQ]      one-hot grant (transfer = valid & ready)
//   req_angle    [NUM_REQ*65]   flattened angles, requester i at [65*i +: 65]
//   req_scale    [NUM_REQ*65]   flattened amplitude scales, same packing
//   hold                        blocks new grants; in-flight work continues
//   resp_valid   [NUM_REQ]      one-hot single-cycle result strobe
//   resp_sin     [65]           shared result bus (zero when no strobe)
//   resp_cos     [65]           shared result bus (zero when no strobe)
//   cu_in_valid                 clock enable to the sin/cos unit
//   cu_angle     [65]           operand to the unit (zero when no transfer)
//   cu_scale     [65]           operand to the unit (zero when no transfer)
//   cu_sin       [65]           unit result
//   cu_cos       [65]           unit result
//   cu_out_valid                unit valid; intentionally ignored
//
// Optional feature: define SINCOS_ARB_STATS_EN to add the saturating
// counters stat_grants [NUM_REQ*32] (transfers per requester) and
// stat_busy [32] (cycles with cu_in_valid=1).
// ---------------------------------------------------------------------------
module sincos_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 42
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*65-1:0] req_angle,
  input  logic [NUM_REQ*65-1:0] req_scale,
  input  logic                 hold,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [64:0]          resp_sin,
  output logic [64:0]          resp_cos,
  output logic                 cu_in_valid,
  output logic [64:0]          cu_angle,
  output logic [64:0]          cu_scale,
  input  logic [64:0]          cu_sin,
  input  logic [64:0]          cu_cos,
  input  logic                 cu_out_valid
`ifdef SINCOS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_grants,
  output logic [31:0]           stat_busy
`endif
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_after;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W:0]     idx_sum;
  logic              found;
  logic              grant_allowed;
  logic              transfer;
  logic              tags_busy;
  logic              any_tag;
  logic              final_valid;
  logic [LATENCY-1:0] tag_valid;
  logic [ID_W-1:0]   tag_id [LATENCY];

  // The unit's own valid is redundant with the tag pipe, so it is not used.
  logic unused_cu_out_valid;
  assign unused_cu_out_valid = cu_out_valid;

  // Round-robin search starting at ptr. The candidate index wraps by one
  // subtraction because ptr + k is always below 2*NUM_REQ.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
        idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!found && req_valid[idx_sum[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = idx_sum[ID_W-1:0];
      end
    end
  end

  // Grants are allowed in IDLE and RUN. This lets the first transfer out of
  // IDLE happen without waiting a cycle. DRAIN never grants.
  assign grant_allowed = !rst && !hold && (state != DRAIN);
  assign transfer      = grant_allowed && found;
  assign ptr_after     = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

  // Only the grant and the operand mux depend on the transfer. Operands
  // stay zero otherwise, so an idle unit sees quiet inputs.
  always_comb begin
    req_ready = '0;
    cu_angle  = '0;
    cu_scale  = '0;
    if (transfer) begin
      req_ready = NUM_REQ'(1) << grant_id;
      cu_angle  = req_angle[int'(grant_id)*65 +: 65];
      cu_scale  = req_scale[int'(grant_id)*65 +: 65];
    end
  end

  // The final stage marks a result that the frozen unit is already showing
  // on its outputs, so it needs no further enable. Only stages 0..LATENCY-2
  // (work still inside the unit) keep the unit running.
  assign tags_busy   = |tag_valid[LATENCY-2:0];
  assign any_tag     = |tag_valid;
  assign cu_in_valid = !rst && (transfer || tags_busy);
  assign final_valid = !rst && tag_valid[LATENCY-1];

  // Response steering: a valid final tag selects the requester and exposes
  // the unit's result for exactly that cycle.
  always_comb begin
    resp_valid = '0;
    resp_sin   = '0;
    resp_cos   = '0;
    if (final_valid) begin
      resp_valid = NUM_REQ'(1) << tag_id[LATENCY-1];
      resp_sin   = cu_sin;
      resp_cos   = cu_cos;
    end
  end

  // Tag valid pipe. It shifts in lockstep with the unit enable; bubbles
  // enter as invalid tags. When the unit is not enabled, every stage below
  // the last is already empty, and a valid last stage has just been
  // delivered, so the whole pipe clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
    end else if (cu_in_valid) begin
      tag_valid <= {tag_valid[LATENCY-2:0], transfer};
    end else begin
      tag_valid <= '0;
    end
  end

  // Tag ids carry no reset; they are only looked at under a valid tag.
  always_ff @(posedge clk) begin
    if (cu_in_valid) begin
      tag_id[0] <= grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // The round-robin pointer moves just past the winner, and only on a real
  // transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (transfer) begin
      ptr <= ptr_after;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. RUN parks in DRAIN while hold blocks grants with work
  // still in flight. Any state with nothing in flight and nothing granted
  // falls back to IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (transfer) state_next = RUN;
      end
      RUN: begin
        if (hold && any_tag)            state_next = DRAIN;
        else if (!any_tag && !transfer) state_next = IDLE;
      end
      DRAIN: begin
        if (!hold)         state_next = RUN;
        else if (!any_tag) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SINCOS_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_REQ];
  logic [31:0] busy_cnt;

  // Saturating activity counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      if (cu_in_valid && (busy_cnt != 32'hFFFF_FFFF)) begin
        busy_cnt <= busy_cnt + 32'd1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (grant_cnt[i] != 32'hFFFF_FFFF)) begin
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_grants[32*i +: 32] = grant_cnt[i];
    end
  end

  assign stat_busy = busy_cnt;
`endif

endmodule

// File: tb/tb_sincos_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sincos_arbiter
//
// Directed bench for sincos_arbiter. A behavioural model of the sin/cos unit
// sits on the cu_* side. The model is a LATENCY-deep pipeline, advanced only
// by cu_in_valid, and it computes scale*sin/cos from real math on 65-bit
// signed Q32.32 operands. Each cycle the bench records the outputs into logs,
// then compares them against hand-derived cycle numbers and values.
// If SINCOS_ARB_STATS_EN is defined, the statistics ports are checked too.
// ---------------------------------------------------------------------------
module tb_sincos_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LATENCY = 42;
  localparam int LOG_N   = 256;
  localparam real PI     = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*65-1:0] req_angle;
  logic [NUM_REQ*65-1:0] req_scale;
  logic                  hold;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [64:0]           resp_sin;
  logic [64:0]           resp_cos;
  logic                  cu_in_valid;
  logic [64:0]           cu_angle;
  logic [64:0]           cu_scale;
  logic [64:0]           cu_sin;
  logic [64:0]           cu_cos;
  logic                  cu_out_valid;
`ifdef SINCOS_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] stat_grants;
  logic [31:0]           stat_busy;
`endif

  int cycle;
  int compared   = 0;
  int mismatched = 0;

  logic [NUM_REQ-1:0] ready_log [LOG_N];
  logic [NUM_REQ-1:0] resp_log  [LOG_N];
  logic               civ_log   [LOG_N];
  logic [64:0]        rsin_log  [LOG_N];
  logic [64:0]        rcos_log  [LOG_N];

  logic [64:0] m_sin [LATENCY];
  logic [64:0] m_cos [LATENCY];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  sincos_arbiter #(
    .NUM_REQ(NUM_REQ),
    .LATENCY(LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_angle   (req_angle),
    .req_scale   (req_scale),
    .hold        (hold),
    .resp_valid  (resp_valid),
    .resp_sin    (resp_sin),
    .resp_cos    (resp_cos),
    .cu_in_valid (cu_in_valid),
    .cu_angle    (cu_angle),
    .cu_scale    (cu_scale),
    .cu_sin      (cu_sin),
    .cu_cos      (cu_cos),
    .cu_out_valid(cu_out_valid)
`ifdef SINCOS_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_busy   (stat_busy)
`endif
  );

  function automatic real from_fx(input logic [64:0] x);
    longint v;
    v = longint'(x[63:0]);
    return real'(v) / 4294967296.0;
  endfunction

  function automatic logic [64:0] to_fx(input real r);
    longint v;
    v = longint'(r * 4294967296.0);
    return {v[63], v};
  endfunction

  function automatic logic close(input logic [64:0] x, input real e);
    real d;
    d = from_fx(x) - e;
    if (d < 0.0) d = -d;
    return (d <= 1.0 / 1048576.0);
  endfunction

  // Model of the sin/cos unit. It advances only when enabled, so it freezes
  // whenever the arbiter stops enabling it, and it is never reset.
  always @(posedge clk) begin
    if (cu_in_valid) begin
      m_sin[0] <= to_fx(from_fx(cu_scale) * $sin(from_fx(cu_angle)));
      m_cos[0] <= to_fx(from_fx(cu_scale) * $cos(from_fx(cu_angle)));
      for (int i = 1; i < LATENCY; i++) begin
        m_sin[i] <= m_sin[i-1];
        m_cos[i] <= m_cos[i-1];
      end
    end
  end
  assign cu_sin       = m_sin[LATENCY-1];
  assign cu_cos       = m_cos[LATENCY-1];
  assign cu_out_valid = 1'b1;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < LOG_N; i++) begin
      ready_log[i] = '0;
      resp_log[i]  = '0;
      civ_log[i]   = 1'b0;
      rsin_log[i]  = '0;
      rcos_log[i]  = '0;
    end
  endtask

  // One cycle. Inputs were set just after the previous rising edge. The
  // outputs are logged on the falling edge, then the bench steps past the
  // next rising edge.
  task automatic run_cycle();
    @(negedge clk);
    if (cycle < LOG_N) begin
      ready_log[cycle] = req_ready;
      resp_log[cycle]  = resp_valid;
      civ_log[cycle]   = cu_in_valid;
      rsin_log[cycle]  = resp_sin;
      rcos_log[cycle]  = resp_cos;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic hold_v,
                               input int n);
    req_valid = valid;
    hold      = hold_v;
    repeat (n) run_cycle();
  endtask

  task automatic set_req(input int i, input real ang, input real scl);
    req_angle[65*i +: 65] = to_fx(ang);
    req_scale[65*i +: 65] = to_fx(scl);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    hold      = 1'b0;
    run_cycle();
    run_cycle();
    rst   = 1'b0;
    cycle = 0;
    clear_logs();
  endtask

  function automatic int count_resp(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (resp_log[i] != '0) n++;
    return n;
  endfunction

  function automatic int count_civ(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (civ_log[i]) n++;
    return n;
  endfunction

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_angle = '0;
    req_scale = '0;
    cycle     = 0;
    clear_logs();
    @(posedge clk);
    #1;

    // Reset state, with requests pending that must not be granted.
    req_valid = 4'hF;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0.1 * (i + 1), 1.0);
    @(negedge clk);
    checkOutput("rst_ready", 64'(req_ready), 64'h0);
    checkOutput("rst_civ", 64'(cu_in_valid), 64'h0);
    checkOutput("rst_resp", 64'(resp_valid), 64'h0);
    checkOutput("rst_cu_angle", cu_angle[63:0], 64'h0);
    @(posedge clk);
    #1;

    // Single request: requester 2, angle pi/6, scale 1.0.
    do_reset();
    set_req(2, PI / 6.0, 1.0);
    applyStimulus(4'b0100, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 55);
    checkOutput("single_ready_c0", 64'(ready_log[0]), 64'h4);
    checkOutput("single_resp_c41", 64'(resp_log[41]), 64'h0);
    checkOutput("single_resp_c42", 64'(resp_log[42]), 64'h4);
    checkOutput("single_resp_c43", 64'(resp_log[43]), 64'h0);
    checkOutput("single_sin", 64'(close(rsin_log[42], 0.5)), 64'h1);
    checkOutput("single_cos", 64'(close(rcos_log[42], 0.8660254037844386)), 64'h1);
    checkOutput("single_resp_count", 64'(count_resp(0, 55)), 64'd1);

    // Fairness: all four requesters continuously for 100 cycles.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0.1 * (i + 1), 1.0);
    applyStimulus(4'hF, 1'b0, 100);
`ifdef SINCOS_ARB_STATS_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      checkOutput($sformatf("stat_grants_%0d", i), 64'(stat_grants[32*i +: 32]), 64'd25);
    end
    checkOutput("stat_busy", 64'(stat_busy), 64'd100);
`endif
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("fair_ready_c%0d", k), 64'(ready_log[k]), 64'(1 << (k % 4)));
    end
    checkOutput("fair_resp_c41", 64'(resp_log[41]), 64'h0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("fair_resp_c%0d", 42 + k), 64'(resp_log[42 + k]),
                  64'(1 << (k % 4)));
    end
    checkOutput("fair_sin_c42", 64'(close(rsin_log[42], $sin(0.1))), 64'h1);
    checkOutput("fair_cos_c45", 64'(close(rcos_log[45], $cos(0.4))), 64'h1);
    applyStimulus(4'h0, 1'b0, 50);

    // Bubble and idle: transfers at cycles 0 and 5 only.
    do_reset();
    set_req(0, 0.3, 2.0);
    set_req(1, 0.7, 0.5);
    applyStimulus(4'b0001, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 4);
    applyStimulus(4'b0010, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 60);
    checkOutput("bub_ready_c5", 64'(ready_log[5]), 64'h2);
    checkOutput("bub_civ_0_46", 64'(count_civ(0, 46)), 64'd47);
    checkOutput("bub_civ_c47", 64'(civ_log[47]), 64'h0);
    checkOutput("bub_civ_after", 64'(count_civ(47, 65)), 64'd0);
    checkOutput("bub_resp_c42", 64'(resp_log[42]), 64'h1);
    checkOutput("bub_resp_c47", 64'(resp_log[47]), 64'h2);
    checkOutput("bub_resp_count", 64'(count_resp(0, 65)), 64'd2);
    checkOutput("bub_sin_c47", 64'(close(rsin_log[47], 0.5 * $sin(0.7))), 64'h1);

    // Hold from cycle 3 to 10 during continuous requests.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0.2 * (i + 1), 1.0);
    applyStimulus(4'hF, 1'b0, 3);
    applyStimulus(4'hF, 1'b1, 8);
    applyStimulus(4'hF, 1'b0, 46);
    checkOutput("hold_ready_c2", 64'(ready_log[2]), 64'h4);
    begin
      int n = 0;
      for (int i = 3; i <= 10; i++) if (ready_log[i] != '0) n++;
      checkOutput("hold_no_ready_3_10", 64'(n), 64'd0);
    end
    checkOutput("hold_drain_ready_c11", 64'(ready_log[11]), 64'h0);
    checkOutput("hold_ready_c12", 64'(ready_log[12]), 64'h8);
    checkOutput("hold_resp_c42", 64'(resp_log[42]), 64'h1);
    checkOutput("hold_resp_c43", 64'(resp_log[43]), 64'h2);
    checkOutput("hold_resp_c44", 64'(resp_log[44]), 64'h4);
    checkOutput("hold_gap_45_53", 64'(count_resp(45, 53)), 64'd0);
    checkOutput("hold_resp_c54", 64'(resp_log[54]), 64'h8);
    applyStimulus(4'h0, 1'b0, 50);

    // Reset in the middle of flight after 10 transfers.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 0.05 * (i + 1), 1.0);
    applyStimulus(4'hF, 1'b0, 10);
    applyStimulus(4'h0, 1'b0, 10);
    rst = 1'b1;
    run_cycle();
    checkOutput("midrst_civ_c20", 64'(civ_log[20]), 64'h0);
    checkOutput("midrst_resp_c20", 64'(resp_log[20]), 64'h0);
    rst   = 1'b0;
    cycle = 0;
    clear_logs();
    applyStimulus(4'h0, 1'b0, 100);
    checkOutput("midrst_no_resp", 64'(count_resp(0, 99)), 64'd0);
    checkOutput("midrst_no_civ", 64'(count_civ(0, 99)), 64'd0);
    cycle = 0;
    clear_logs();
    set_req(1, 1.0, 1.0);
    applyStimulus(4'b0010, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 50);
    checkOutput("post_ready_c0", 64'(ready_log[0]), 64'h2);
    checkOutput("post_early", 64'(count_resp(0, 41)), 64'd0);
    checkOutput("post_resp_c42", 64'(resp_log[42]), 64'h2);
    checkOutput("post_sin_c42", 64'(close(rsin_log[42], $sin(1.0))), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
